// File: rtl/shot_clock_pkg.sv
// Shared constants for the shot-clock controller: FSM encoding and default presets.
package shot_clock_pkg;

  typedef logic [1:0] shot_state_t;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_PAUSE   = 2'd2;
  localparam logic [1:0] ST_EXPIRED = 2'd3;

  localparam int T_FULL_DEF   = 24;
  localparam int T_SHORT_DEF  = 14;
  localparam int BUZZ_LEN_DEF = 3;

endpackage

// File: rtl/shot_bcd.sv
// Binary to two-digit BCD; also used by the game-clock display, so kept generic in N.
module shot_bcd #(
  parameter int N = 8
) (
  input  logic [N-1:0] i_bin,
  output logic [3:0]   o_tens,
  output logic [3:0]   o_ones
);

  // Only meaningful for i_bin <= 99; larger inputs lose the hundreds.
  assign o_tens = 4'(i_bin / N'(10));
  assign o_ones = 4'(i_bin % N'(10));

endmodule

// File: rtl/shot_clock_ctrl.sv
// Shot-clock controller: preset loads, run/pause/expired FSM, timed buzzer,
// display blanking against the game clock and BCD digit outputs.
module shot_clock_ctrl
  import shot_clock_pkg::*;
#(
  parameter int N        = 8,
  parameter int GN       = 12,
  parameter int T_FULL   = T_FULL_DEF,
  parameter int T_SHORT  = T_SHORT_DEF,
  parameter int BUZZ_LEN = BUZZ_LEN_DEF
) (
  input  logic          clk_1Hz,
  input  logic          Reset_n,
  input  logic          en,
  input  logic          load_full,
  input  logic          load_short,
  input  logic          load_custom,
  input  logic [N-1:0]  load_val,
  input  logic [GN-1:0] game_time,
  output logic [N-1:0]  reg_N,
  output logic [3:0]    digit_tens,
  output logic [3:0]    digit_ones,
  output logic          running,
  output logic          stop,
  output logic          cout,
  output logic          expired,
  output logic          buzzer,
  output logic          blank
);

  localparam int BW = (BUZZ_LEN > 1) ? $clog2(BUZZ_LEN) : 1;
  localparam int CW = (N > GN) ? N : GN;

  generate
    if (T_FULL > 99 || T_FULL < 1 || T_SHORT < 1 || T_SHORT > T_FULL || BUZZ_LEN < 1) begin : g_param_err
      $error("shot_clock_ctrl: illegal preset or buzzer parameters");
    end
  endgenerate

  shot_state_t   r_state;
  logic [N-1:0]  r_count;
  logic          r_cout;
  logic          r_buzzer;
  logic [BW-1:0] r_bcnt;
  logic          r_blank;

  logic          w_load;
  logic [N-1:0]  w_load_val;
  logic [CW-1:0] w_game_ext;
  logic [CW-1:0] w_count_ext;

  // A zero custom preset would strand the clock at 0 outside EXPIRED, so it is dropped.
  assign w_load = load_full | load_short | (load_custom & (load_val != '0));

  always_comb begin
    w_load_val = N'(T_FULL);
    if (load_full)
      w_load_val = N'(T_FULL);
    else if (load_short)
      w_load_val = N'(T_SHORT);
    else if (load_val > N'(T_FULL))
      w_load_val = N'(T_FULL);
    else
      w_load_val = load_val;
  end

  assign w_game_ext  = CW'(game_time);
  assign w_count_ext = CW'(r_count);

  always_ff @(posedge clk_1Hz or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state  <= ST_IDLE;
      r_count  <= N'(T_FULL);
      r_cout   <= 1'b0;
      r_buzzer <= 1'b0;
      r_bcnt   <= '0;
      r_blank  <= 1'b0;
    end else begin
      r_blank <= (w_game_ext < w_count_ext);
      r_cout  <= 1'b0;
      if (w_load) begin
        r_count  <= w_load_val;
        r_state  <= ST_IDLE;
        r_buzzer <= 1'b0;
        r_bcnt   <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (en) r_state <= ST_RUN;
          end
          ST_RUN: begin
            if (!en) begin
              r_state <= ST_PAUSE;
            end else if (r_count <= N'(1)) begin
              r_count  <= '0;
              r_state  <= ST_EXPIRED;
              r_cout   <= 1'b1;
              r_buzzer <= 1'b1;
              r_bcnt   <= BW'(BUZZ_LEN - 1);
            end else begin
              r_count <= r_count - N'(1);
            end
          end
          ST_PAUSE: begin
            if (en) r_state <= ST_RUN;
          end
          default: begin
            // Buzzer drops on the edge that finds the counter already at zero.
            if (r_bcnt == '0)
              r_buzzer <= 1'b0;
            else
              r_bcnt <= r_bcnt - BW'(1);
          end
        endcase
      end
    end
  end

  shot_bcd #(.N(N)) u_bcd (
    .i_bin  (r_count),
    .o_tens (digit_tens),
    .o_ones (digit_ones)
  );

  assign reg_N   = r_count;
  assign running = (r_state == ST_RUN);
  assign stop    = (r_state != ST_RUN);
  assign expired = (r_state == ST_EXPIRED);
  assign cout    = r_cout;
  assign buzzer  = r_buzzer;
  assign blank   = r_blank;

endmodule

// File: tb/tb_shot_clock_ctrl.sv
// Self-checking bench for shot_clock_ctrl: directed scenarios plus randomized traffic
// compared every edge against a behavioural model of the shot-clock rules.
module tb_shot_clock_ctrl;

  localparam int FULL = 24;
  localparam int SHORT = 14;
  localparam int BLEN = 3;

  localparam int PH_IDLE = 0;
  localparam int PH_RUN = 1;
  localparam int PH_PAUSE = 2;
  localparam int PH_EXP = 3;

  logic        clk_1Hz;
  logic        Reset_n;
  logic        en;
  logic        load_full;
  logic        load_short;
  logic        load_custom;
  logic [7:0]  load_val;
  logic [11:0] game_time;
  logic [7:0]  reg_N;
  logic [3:0]  digit_tens;
  logic [3:0]  digit_ones;
  logic        running;
  logic        stop;
  logic        cout;
  logic        expired;
  logic        buzzer;
  logic        blank;

  int n_tests = 0;
  int n_fail = 0;

  // Model: seconds remaining, phase, buzzer cycles still to sound, registered flags.
  int m_count;
  int m_phase;
  int m_left;
  bit m_cout;
  bit m_blank;

  logic [21:0] obs;
  assign obs = {reg_N, digit_tens, digit_ones, running, stop, cout, expired, buzzer, blank};

  shot_clock_ctrl dut (
    .clk_1Hz     (clk_1Hz),
    .Reset_n     (Reset_n),
    .en          (en),
    .load_full   (load_full),
    .load_short  (load_short),
    .load_custom (load_custom),
    .load_val    (load_val),
    .game_time   (game_time),
    .reg_N       (reg_N),
    .digit_tens  (digit_tens),
    .digit_ones  (digit_ones),
    .running     (running),
    .stop        (stop),
    .cout        (cout),
    .expired     (expired),
    .buzzer      (buzzer),
    .blank       (blank)
  );

  initial clk_1Hz = 1'b0;
  always #5 clk_1Hz = ~clk_1Hz;

  function automatic logic [21:0] exp_vec();
    logic [7:0] c;
    logic [3:0] t;
    logic [3:0] o;
    c = 8'(m_count);
    t = 4'(m_count / 10);
    o = 4'(m_count % 10);
    return {c, t, o, (m_phase == PH_RUN), (m_phase != PH_RUN), m_cout,
            (m_phase == PH_EXP), (m_left > 0), m_blank};
  endfunction

  task automatic model_reset();
    m_count = FULL;
    m_phase = PH_IDLE;
    m_left = 0;
    m_cout = 0;
    m_blank = 0;
  endtask

  // One rising edge worth of shot-clock rules applied to the model.
  task automatic model_edge();
    bit nb;
    bit ld;
    nb = (int'(game_time) < m_count);
    ld = load_full || load_short || (load_custom && load_val != 0);
    m_cout = 0;
    if (ld) begin
      if (load_full) m_count = FULL;
      else if (load_short) m_count = SHORT;
      else m_count = (int'(load_val) > FULL) ? FULL : int'(load_val);
      m_phase = PH_IDLE;
      m_left = 0;
    end else begin
      case (m_phase)
        PH_IDLE:  if (en) m_phase = PH_RUN;
        PH_PAUSE: if (en) m_phase = PH_RUN;
        PH_RUN: begin
          if (!en) m_phase = PH_PAUSE;
          else if (m_count == 1) begin
            m_count = 0;
            m_phase = PH_EXP;
            m_cout = 1;
            m_left = BLEN;
          end else m_count = m_count - 1;
        end
        default: if (m_left > 0) m_left = m_left - 1;
      endcase
    end
    m_blank = nb;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk_1Hz);
    #1;
  endtask

  task automatic clear_loads();
    load_full = 0;
    load_short = 0;
    load_custom = 0;
  endtask

  task automatic test_reset();
    #2 Reset_n = 0;
    #1 model_reset();
    if (obs !== exp_vec()) begin n_fail++; $display("FAIL reset_state: got %h want %h", obs, exp_vec()); end
    n_tests++;
    @(posedge clk_1Hz); #1;
    Reset_n = 1;
    en = 1;
    step();
    if (obs !== exp_vec()) begin n_fail++; $display("FAIL reset_to_run: got %h want %h", obs, exp_vec()); end
    n_tests++;
    step();
    if (obs !== exp_vec() || digit_tens !== 4'd2 || digit_ones !== 4'd3) begin
      n_fail++; $display("FAIL first_decrement: got %h want %h", obs, exp_vec());
    end
    n_tests++;
  endtask

  task automatic test_expiry();
    int n_cout = 0;
    int n_buzz = 0;
    for (int i = 0; i < 40 && m_phase != PH_EXP; i++) begin
      step();
      n_cout += int'(cout);
      n_buzz += int'(buzzer);
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL countdown: got %h want %h", obs, exp_vec()); end
      n_tests++;
    end
    for (int i = 0; i < 8; i++) begin
      en = 1'($urandom_range(0, 1));
      step();
      n_cout += int'(cout);
      n_buzz += int'(buzzer);
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL expired_hold: got %h want %h", obs, exp_vec()); end
      n_tests++;
    end
    if (n_cout != 1) begin n_fail++; $display("FAIL cout_cycles: got %0d want 1", n_cout); end
    n_tests++;
    if (n_buzz != BLEN) begin n_fail++; $display("FAIL buzz_cycles: got %0d want %0d", n_buzz, BLEN); end
    n_tests++;
  endtask

  task automatic test_load_priority();
    load_full = 1;
    step();
    clear_loads();
    if (obs !== exp_vec()) begin n_fail++; $display("FAIL reload_full: got %h want %h", obs, exp_vec()); end
    n_tests++;
    en = 1;
    for (int i = 0; i < 40 && m_count != 9; i++) begin
      step();
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL run_to_9: got %h want %h", obs, exp_vec()); end
      n_tests++;
    end
    load_short = 1;
    load_custom = 1;
    load_val = 8'd5;
    step();
    clear_loads();
    if (obs !== exp_vec() || reg_N !== 8'd14 || running !== 1'b0) begin
      n_fail++; $display("FAIL short_over_custom: got %h want %h", obs, exp_vec());
    end
    n_tests++;
    load_full = 1;
    step();
    clear_loads();
    if (obs !== exp_vec() || reg_N !== 8'd24) begin n_fail++; $display("FAIL full_after_short: got %h want %h", obs, exp_vec()); end
    n_tests++;
  endtask

  task automatic test_pause();
    en = 1;
    for (int i = 0; i < 40 && !(m_phase == PH_RUN && m_count == 17); i++) begin
      step();
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL run_to_17: got %h want %h", obs, exp_vec()); end
      n_tests++;
    end
    en = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (obs !== exp_vec() || reg_N !== 8'd17 || stop !== 1'b1) begin
        n_fail++; $display("FAIL pause_hold: got %h want %h", obs, exp_vec());
      end
      n_tests++;
    end
    en = 1;
    step();
    if (obs !== exp_vec() || reg_N !== 8'd17) begin n_fail++; $display("FAIL resume_no_dec: got %h want %h", obs, exp_vec()); end
    n_tests++;
    step();
    if (obs !== exp_vec() || reg_N !== 8'd16) begin n_fail++; $display("FAIL resume_dec: got %h want %h", obs, exp_vec()); end
    n_tests++;
  endtask

  task automatic test_custom();
    en = 0;
    step();
    load_custom = 1;
    load_val = 8'd0;
    step();
    if (obs !== exp_vec()) begin n_fail++; $display("FAIL custom_zero: got %h want %h", obs, exp_vec()); end
    n_tests++;
    load_val = 8'd40;
    step();
    clear_loads();
    if (obs !== exp_vec() || reg_N !== 8'd24) begin n_fail++; $display("FAIL custom_clamp: got %h want %h", obs, exp_vec()); end
    n_tests++;
    load_custom = 1;
    load_val = 8'd7;
    step();
    clear_loads();
    if (obs !== exp_vec() || reg_N !== 8'd7) begin n_fail++; $display("FAIL custom_7: got %h want %h", obs, exp_vec()); end
    n_tests++;
  endtask

  task automatic test_load_at_expiry();
    load_custom = 1;
    load_val = 8'd2;
    step();
    clear_loads();
    en = 1;
    step();
    step();
    if (obs !== exp_vec() || reg_N !== 8'd1) begin n_fail++; $display("FAIL pre_expiry: got %h want %h", obs, exp_vec()); end
    n_tests++;
    load_full = 1;
    step();
    clear_loads();
    if (obs !== exp_vec() || cout !== 1'b0 || buzzer !== 1'b0) begin
      n_fail++; $display("FAIL load_beats_expiry: got %h want %h", obs, exp_vec());
    end
    n_tests++;
  endtask

  task automatic test_blank();
    en = 0;
    game_time = 12'd10;
    load_short = 1;
    step();
    clear_loads();
    step();
    if (obs !== exp_vec() || blank !== 1'b1) begin n_fail++; $display("FAIL blank_on: got %h want %h", obs, exp_vec()); end
    n_tests++;
    game_time = 12'd20;
    step();
    if (obs !== exp_vec() || blank !== 1'b0) begin n_fail++; $display("FAIL blank_off: got %h want %h", obs, exp_vec()); end
    n_tests++;
  endtask

  task automatic test_reset_mid_buzz();
    game_time = 12'd100;
    load_custom = 1;
    load_val = 8'd1;
    step();
    clear_loads();
    en = 1;
    step();
    step();
    step();
    if (obs !== exp_vec() || buzzer !== 1'b1) begin n_fail++; $display("FAIL buzz_before_reset: got %h want %h", obs, exp_vec()); end
    n_tests++;
    #2 Reset_n = 0;
    #1 model_reset();
    if (obs !== exp_vec() || buzzer !== 1'b0 || reg_N !== 8'd24) begin
      n_fail++; $display("FAIL async_reset_buzz: got %h want %h", obs, exp_vec());
    end
    n_tests++;
    @(posedge clk_1Hz); #1;
    Reset_n = 1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      en = ($urandom_range(0, 3) != 0);
      load_full = ($urandom_range(0, 29) == 0);
      load_short = ($urandom_range(0, 19) == 0);
      load_custom = ($urandom_range(0, 9) == 0);
      load_val = 8'($urandom_range(0, 40));
      game_time = 12'($urandom_range(0, 30));
      if ($urandom_range(0, 149) == 0) begin
        Reset_n = 0;
        #1 model_reset();
        if (obs !== exp_vec()) begin n_fail++; $display("FAIL rand_reset: got %h want %h", obs, exp_vec()); end
        n_tests++;
        @(posedge clk_1Hz); #1;
        Reset_n = 1;
      end else begin
        step();
        if (obs !== exp_vec()) begin
          n_fail++; $display("FAIL rand_edge %0d: got %h want %h", i, obs, exp_vec());
        end
        n_tests++;
      end
    end
    clear_loads();
  endtask

  initial begin
    Reset_n = 1;
    en = 0;
    load_full = 0;
    load_short = 0;
    load_custom = 0;
    load_val = '0;
    game_time = 12'd100;
    model_reset();
    test_reset();
    test_expiry();
    test_load_priority();
    test_pause();
    test_custom();
    test_load_at_expiry();
    test_blank();
    test_reset_mid_buzz();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
